// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: unsigned 8x8 -> 16-bit multiplier built by reusing one
// 4x4 array multiplier over four cycles (one nibble-pair partial product
// per cycle), with valid/ready handshakes on the operand and result sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is a pure decode of the IDLE state. out_valid and
// out_p are registered and stay stable until out_ready is seen in DONE.

// four_x_four_Multiplier: combinational 4x4 unsigned array multiplier, y = a*b.
module four_x_four_Multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);
    // Shift-and-add over the rows of the partial-product array
    always_comb begin
        y = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                y = y + ({4'h0, a} << i);
            end
        end
    end
endmodule

module mul8_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        r_out_valid;
    logic [15:0] r_out_p;

    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [7:0]  w_prod;
    logic [15:0] w_pp;

    // Nibble selection and partial-product alignment, driven only from the
    // latched operands so input changes while busy cannot leak in
    always_comb begin
        w_nib_a = r_a[3:0];
        w_nib_b = r_b[3:0];
        w_pp    = 16'h0000;
        case (r_state)
            S_P0: begin
                w_nib_a = r_a[3:0];
                w_nib_b = r_b[3:0];
                w_pp    = {8'h00, w_prod};
            end
            S_P1: begin
                w_nib_a = r_a[7:4];
                w_nib_b = r_b[3:0];
                w_pp    = {4'h0, w_prod, 4'h0};
            end
            S_P2: begin
                w_nib_a = r_a[3:0];
                w_nib_b = r_b[7:4];
                w_pp    = {4'h0, w_prod, 4'h0};
            end
            S_P3: begin
                w_nib_a = r_a[7:4];
                w_nib_b = r_b[7:4];
                w_pp    = {w_prod, 8'h00};
            end
            default: begin
                w_nib_a = r_a[3:0];
                w_nib_b = r_b[3:0];
                w_pp    = 16'h0000;
            end
        endcase
    end

    four_x_four_Multiplier u_mul (
        .a (w_nib_a),
        .b (w_nib_b),
        .y (w_prod)
    );

    // Sequencing FSM with operand, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_acc       <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_p     <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_acc   <= 16'h0000;
                        r_state <= S_P0;
                    end
                end
                S_P0: begin
                    r_acc   <= r_acc + w_pp;
                    r_state <= S_P1;
                end
                S_P1: begin
                    r_acc   <= r_acc + w_pp;
                    r_state <= S_P2;
                end
                S_P2: begin
                    r_acc   <= r_acc + w_pp;
                    r_state <= S_P3;
                end
                S_P3: begin
                    // Max sum is 255*255 = 16'hFE01, so no carry-out is needed
                    r_out_p     <= r_acc + w_pp;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    // Undefined encodings recover to IDLE
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks for mul8_seq_ctrl. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_mul8_seq_ctrl;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int n_hs    = 0;
  logic [15:0] exp_q[$];

  mul8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count completed result handshakes
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) n_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one operand pair for a single cycle; caller ensures IDLE
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // wait (bounded) for out_valid; cyc = falling edges waited
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // wait (bounded) for IDLE
  task automatic wait_ready();
    int c;
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
  endtask

  // full operation with out_ready already high; checks latency and product
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int cyc;
    wait_ready();
    accept(a, b);
    wait_valid(cyc);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_p"}, out_p, exp);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rr;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // 0x12 * 0x34 step by step
    accept(8'h12, 8'h34);
    chk("t1_busy", busy, 1'b1);
    chk("t1_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_not_early", out_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_p", out_p, 16'h03A8);
    chk("t1_in_ready_done", in_ready, 1'b0);
    @(negedge clk);
    chk("t1_in_ready_back", in_ready, 1'b1);
    chk("t1_valid_low", out_valid, 1'b0);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_p_kept", out_p, 16'h03A8);

    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("zero_a", 8'h00, 8'hA5, 16'h0000);

    // backpressure
    out_ready = 1'b0;
    wait_ready();
    accept(8'h0F, 8'hF0);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_p", out_p, 16'h0E10);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    chk("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);

    // operands change while busy with in_valid held high
    in_a = 8'h12;
    in_b = 8'h34;
    in_valid = 1'b1;
    @(negedge clk);
    in_a = 8'hFF;
    in_b = 8'hFF;
    wait_valid(cyc);
    chk("hold_latency", cyc, 4);
    chk("hold_p1", out_p, 16'h03A8);
    @(negedge clk);
    chk("hold_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_second_accept", busy, 1'b1);
    wait_valid(cyc);
    chk("hold_p2_valid", out_valid, 1'b1);
    chk("hold_p2", out_p, 16'hFE01);
    @(negedge clk);
    chk("hold_no_extra", busy, 1'b0);

    // asynchronous reset during P2
    accept(8'h77, 8'h99);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_p", out_p, 16'h0000);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", in_ready, 1'b1);
    run_op("post_rst", 8'h03, 8'h05, 16'h000F);

    // random sweep with random backpressure
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(16'(ra) * 16'(rb));
      out_ready = 1'($urandom_range(0, 1));
      wait_ready();
      accept(ra, rb);
      wait_valid(cyc);
      if (!out_valid) begin
        chk("rnd_timeout", out_valid, 1'b1);
        void'(exp_q.pop_front());
      end else begin
        rr = 1'b0;
        for (int k = 0; k < 50 && !rr; k++) begin
          rr = 1'($urandom_range(0, 1));
          out_ready = rr;
          if (rr) chk("rnd_p", out_p, exp_q.pop_front());
          @(negedge clk);
        end
        if (!rr) begin
          out_ready = 1'b1;
          chk("rnd_p", out_p, exp_q.pop_front());
          @(negedge clk);
        end
      end
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("result_count", n_hs, 1007);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
